spi_frame_ctrl: RTL and testbench
=================================

Name: spi_frame_ctrl

Overview:
Frame-level controller that sequences the SPI slave shifter datapath for one frame at a time.
- At frame start it snapshots the feedback word into the transmit frame.
- At frame end it validates the received frame by length and MSGID, commits the command payload, and runs the link watchdog.
- It sits between the raw SPI shifter and the motion/IO register file, so downstream logic sees only atomic, validated frames.

Parameters:
BUFFER_SIZE, 64, frame length in bits; header occupies the top 32 bits.
MSGID, 32'h74697277, required header value of a valid frame.
TIMEOUT, 4800000, clk cycles without a committed frame before the link is declared dead.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; asynchronous, active-low.
SPI_SSEL  in  1  raw chip select, asynchronous, active low.
frame_rx  in  BUFFER_SIZE  shifter receive register; stable while SPI_SSEL is high.
bit_count  in  16  shifter SCK rising-edge count for the current frame.
status_in  in  BUFFER_SIZE-32  feedback payload from the register file.
tx_frame  out  BUFFER_SIZE  frame loaded into the shifter: {MSGID, snapshot}.
cmd_out  out  BUFFER_SIZE-32  last committed command payload.
cmd_valid  out  1  one-cycle pulse when cmd_out updates.
link_enable  out  1  high while the link is alive; gates outputs downstream.
pkg_timeout  out  1  high when the watchdog has expired.
short_cnt  out  8  saturating count of frames with bit_count != BUFFER_SIZE.
bad_id_cnt  out  8  saturating count of full-length frames with a wrong header.

Behaviour:
- SPI_SSEL passes through a 3-flop history, ssr[2:0]. Decoded signals:
  - sync level = ssr[1].
  - rise = (ssr[2:1]==2'b01).
- Reset values:
  - tx_frame = {MSGID, 0}.
  - cmd_out = 0, cmd_valid = 0, link_enable = 0, pkg_timeout = 1.
  - short_cnt = 0, bad_id_cnt = 0.
  - watchdog = TIMEOUT (expired).
  - ssr = 3'b111.
  - FSM enters WAIT_HIGH.
- FSM states and transitions:
  - WAIT_HIGH: go to IDLE when sync level = 1. Prevents a frame in progress at reset release from being processed.
  - IDLE: when sync level = 0, tx_frame <= {MSGID, status_in} and go to ACTIVE. status_in is sampled exactly once per frame.
  - ACTIVE: on rise, go to CHECK.
  - CHECK, single cycle, evaluated in priority order:
    1. bit_count != BUFFER_SIZE: short_cnt += 1 (saturate at 255), go to IDLE.
    2. frame_rx[BUFFER_SIZE-1:BUFFER_SIZE-32] != MSGID: bad_id_cnt += 1 (saturate at 255), go to IDLE.
    3. Otherwise go to COMMIT.
  - COMMIT, single cycle:
    - cmd_out <= frame_rx[BUFFER_SIZE-33:0], cmd_valid <= 1.
    - watchdog <= 0, link_enable <= 1, pkg_timeout <= 0.
    - Go to IDLE.
- cmd_valid is high for exactly one cycle per committed frame. cmd_out holds its value until the next commit.
- Latency: number the first clk edge that samples SPI_SSEL high as edge 1. cmd_valid and cmd_out update on edge 5.
- Rejected frames leave cmd_out, link_enable and the watchdog untouched.
- Watchdog:
  - Counts +1 per clk while below TIMEOUT and saturates at TIMEOUT.
  - Width = $clog2(TIMEOUT+1).
  - On reaching TIMEOUT, link_enable <= 0 and pkg_timeout <= 1 on the same edge. Both hold until the next COMMIT.
  - If a COMMIT coincides with the expiry edge, COMMIT wins.
- SSEL low again already in CHECK or COMMIT: the frame is not lost. IDLE starts the next frame on the following cycle, because IDLE tests level, not edge.
- A glitch shorter than 2 clk on SPI_SSEL is filtered by the synchronizer only to the extent the flops miss it. A glitch that is captured yields a short frame, which is counted and rejected.
- Reset asserted mid-frame: all state returns to reset values immediately and the FSM waits for SSEL high before any snapshot.

Test Plan:
- Reset release, then a 64-bit frame with header 32'h74697277 and payload 32'h0000_1234 → cmd_out = 32'h0000_1234, cmd_valid = 1 for one cycle at edge 5, link_enable = 1, pkg_timeout = 0.
- status_in = 32'hAAAA_5555 at the SSEL falling edge, changed to 32'h0 mid-frame → tx_frame = 64'h74697277_AAAA5555 for the whole frame.
- Frame with header 32'hDEADBEEF → bad_id_cnt = 1, cmd_out unchanged, no cmd_valid. Frame with bit_count = 40 → short_cnt = 1. 300 short frames → short_cnt = 255.
- TIMEOUT = 100 (override): commit a frame, then idle → pkg_timeout rises exactly 100 clk after the commit edge and link_enable falls. A new valid frame clears both.
- SPI_SSEL held low across reset release → no snapshot and no commit for that frame. The next full frame commits normally.
- Back-to-back frames with SSEL high for 3 clk → both frames commit, with 2 cmd_valid pulses and the correct snapshots.

Source files
------------

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: frame-level sequencer for an SPI slave shifter.
// Snapshots feedback into the transmit frame when a frame starts.
// When a frame ends it checks length and header, then commits the payload.
// It also runs a link watchdog that expires when no frame has been committed
// for TIMEOUT clk cycles.
module spi_frame_ctrl #(
  parameter int          BUFFER_SIZE = 64,
  parameter logic [31:0] MSGID       = 32'h74697277,
  parameter int          TIMEOUT     = 4800000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    SPI_SSEL,
  input  logic [BUFFER_SIZE-1:0]  frame_rx,
  input  logic [15:0]             bit_count,
  input  logic [BUFFER_SIZE-33:0] status_in,
  output logic [BUFFER_SIZE-1:0]  tx_frame,
  output logic [BUFFER_SIZE-33:0] cmd_out,
  output logic                    cmd_valid,
  output logic                    link_enable,
  output logic                    pkg_timeout,
  output logic [7:0]              short_cnt,
  output logic [7:0]              bad_id_cnt
);

  localparam int               PW        = BUFFER_SIZE - 32;
  localparam int               WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT);
  localparam logic [15:0]      FULL_BITS = 16'(BUFFER_SIZE);

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    ACTIVE,
    CHECK,
    COMMIT
  } state_t;

  state_t          state_reg;
  logic [2:0]      ssr_reg;
  logic [1:0]      primed_reg;
  logic [WD_W-1:0] wd_reg;

  logic sync_level;
  logic ssel_rise;

  assign sync_level = ssr_reg[1];
  assign ssel_rise  = (ssr_reg[2:1] == 2'b01);

  // Chip-select synchronizer. The reset preset of ssr is not a real sample,
  // so primed_reg marks when ssr[1] holds a genuinely sampled SSEL level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssr_reg    <= 3'b111;
      primed_reg <= 2'b00;
    end else begin
      ssr_reg    <= {ssr_reg[1:0], SPI_SSEL};
      primed_reg <= {primed_reg[0], 1'b1};
    end
  end

  // Frame FSM with registered outputs and the link watchdog. COMMIT is
  // written after the watchdog update, so a commit on the expiry edge wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= WAIT_HIGH;
      tx_frame    <= {MSGID, {PW{1'b0}}};
      cmd_out     <= '0;
      cmd_valid   <= 1'b0;
      link_enable <= 1'b0;
      pkg_timeout <= 1'b1;
      short_cnt   <= 8'd0;
      bad_id_cnt  <= 8'd0;
      wd_reg      <= WD_MAX;
    end else begin
      cmd_valid <= 1'b0;

      if (wd_reg < WD_MAX) begin
        wd_reg <= wd_reg + 1'b1;
        if (wd_reg == WD_MAX - 1'b1) begin
          link_enable <= 1'b0;
          pkg_timeout <= 1'b1;
        end
      end

      case (state_reg)
        WAIT_HIGH: begin
          // A frame already in progress at reset release is skipped.
          if (primed_reg[1] && sync_level) begin
            state_reg <= IDLE;
          end
        end
        IDLE: begin
          // Level test, so a frame that started during CHECK/COMMIT is kept.
          if (!sync_level) begin
            tx_frame  <= {MSGID, status_in};
            state_reg <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (ssel_rise) begin
            state_reg <= CHECK;
          end
        end
        CHECK: begin
          if (bit_count != FULL_BITS) begin
            if (short_cnt != 8'hFF) begin
              short_cnt <= short_cnt + 8'd1;
            end
            state_reg <= IDLE;
          end else if (frame_rx[BUFFER_SIZE-1 -: 32] != MSGID) begin
            if (bad_id_cnt != 8'hFF) begin
              bad_id_cnt <= bad_id_cnt + 8'd1;
            end
            state_reg <= IDLE;
          end else begin
            state_reg <= COMMIT;
          end
        end
        COMMIT: begin
          cmd_out     <= frame_rx[PW-1:0];
          cmd_valid   <= 1'b1;
          wd_reg      <= '0;
          link_enable <= 1'b1;
          pkg_timeout <= 1'b0;
          state_reg   <= IDLE;
        end
        default: begin
          state_reg <= WAIT_HIGH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Testbench for spi_frame_ctrl: directed frames, with a scoreboard queue of
// expected commit payloads that a monitor checks against every cmd_valid pulse.
module tb_spi_frame_ctrl;

  localparam logic [31:0] MSGID = 32'h74697277;

  logic        clk;
  logic        rst_n;
  logic        SPI_SSEL;
  logic [63:0] frame_rx;
  logic [15:0] bit_count;
  logic [31:0] status_in;
  logic [63:0] tx_frame;
  logic [31:0] cmd_out;
  logic        cmd_valid;
  logic        link_enable;
  logic        pkg_timeout;
  logic [7:0]  short_cnt;
  logic [7:0]  bad_id_cnt;

  int total = 0;
  int bad   = 0;
  int pulses_seen = 0;
  int pulses_exp  = 0;
  logic [31:0] exp_q[$];

  spi_frame_ctrl #(
    .BUFFER_SIZE(64),
    .MSGID(32'h74697277),
    .TIMEOUT(100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .SPI_SSEL(SPI_SSEL),
    .frame_rx(frame_rx),
    .bit_count(bit_count),
    .status_in(status_in),
    .tx_frame(tx_frame),
    .cmd_out(cmd_out),
    .cmd_valid(cmd_valid),
    .link_enable(link_enable),
    .pkg_timeout(pkg_timeout),
    .short_cnt(short_cnt),
    .bad_id_cnt(bad_id_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every cmd_valid pulse must match the oldest expected payload.
  always @(negedge clk) begin
    if (rst_n && cmd_valid) begin
      pulses_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_cmd_valid", {32'h0, cmd_out}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("sb_cmd_out", {32'h0, cmd_out}, {32'h0, exp_q.pop_front()});
      end
      chk("sb_link_pkg", {62'h0, link_enable, pkg_timeout}, 64'h2);
    end
  end

  task automatic check_reset_state();
    chk("rst_tx_frame", tx_frame, {MSGID, 32'h0});
    chk("rst_cmd_out", {32'h0, cmd_out}, 64'h0);
    chk("rst_cmd_valid", {63'h0, cmd_valid}, 64'h0);
    chk("rst_link_enable", {63'h0, link_enable}, 64'h0);
    chk("rst_pkg_timeout", {63'h0, pkg_timeout}, 64'h1);
    chk("rst_counters", {48'h0, short_cnt, bad_id_cnt}, 64'h0);
  endtask

  // One frame: SSEL low for 5 clk (status changes mid-frame), then high.
  // Returns #1 after edge 5, the edge that carries cmd_valid for a commit.
  task automatic run_frame(input logic [63:0] rx, input logic [15:0] bc,
                           input logic [31:0] st, input bit commit);
    @(negedge clk);
    SPI_SSEL  = 1'b0;
    status_in = st;
    frame_rx  = rx;
    bit_count = bc;
    if (commit) begin
      exp_q.push_back(rx[31:0]);
      pulses_exp++;
    end
    repeat (4) @(negedge clk);
    status_in = 32'h0;
    @(negedge clk);
    chk("tx_snapshot", tx_frame, {MSGID, st});
    SPI_SSEL = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("lat_edge4_no_valid", {63'h0, cmd_valid}, 64'h0);
    @(posedge clk);
    #1 chk("lat_edge5_valid", {63'h0, cmd_valid}, {63'h0, commit});
  endtask

  initial begin
    rst_n     = 1'b0;
    SPI_SSEL  = 1'b1;
    frame_rx  = 64'h0;
    bit_count = 16'd0;
    status_in = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Valid frame; snapshot held although status_in changes mid-frame.
    run_frame({MSGID, 32'h0000_1234}, 16'd64, 32'hAAAA_5555, 1'b1);
    chk("commit_cmd_out", {32'h0, cmd_out}, 64'h0000_1234);
    chk("commit_link", {62'h0, link_enable, pkg_timeout}, 64'h2);

    // Wrong header: counted, nothing committed.
    run_frame({32'hDEADBEEF, 32'h0000_9999}, 16'd64, 32'h0000_0001, 1'b0);
    @(negedge clk);
    chk("bad_id_cnt_1", {56'h0, bad_id_cnt}, 64'd1);
    chk("bad_id_cmd_hold", {32'h0, cmd_out}, 64'h0000_1234);
    chk("bad_id_link_hold", {63'h0, link_enable}, 64'h1);

    // Short frame.
    run_frame({MSGID, 32'h0000_7777}, 16'd40, 32'h0000_0002, 1'b0);
    @(negedge clk);
    chk("short_cnt_1", {56'h0, short_cnt}, 64'd1);
    chk("short_cmd_hold", {32'h0, cmd_out}, 64'h0000_1234);

    // Watchdog expires exactly 100 clk after the commit edge.
    run_frame({MSGID, 32'hCAFE_0001}, 16'd64, 32'h0000_0003, 1'b1);
    repeat (99) @(posedge clk);
    #1 chk("wd_99_alive", {62'h0, link_enable, pkg_timeout}, 64'h2);
    @(posedge clk);
    #1 chk("wd_100_expired", {62'h0, link_enable, pkg_timeout}, 64'h1);

    // A new valid frame revives the link.
    run_frame({MSGID, 32'hCAFE_0002}, 16'd64, 32'h0000_0004, 1'b1);
    chk("wd_cleared", {62'h0, link_enable, pkg_timeout}, 64'h2);

    // 299 more short frames: 300 in total, counter saturates.
    for (int i = 0; i < 299; i++) begin
      run_frame({MSGID, 32'h0}, 16'd63, 32'h0000_0005, 1'b0);
    end
    @(negedge clk);
    chk("short_cnt_sat", {56'h0, short_cnt}, 64'd255);

    // Back-to-back frames with SSEL high for only 3 clk in between.
    @(negedge clk);
    SPI_SSEL  = 1'b0;
    status_in = 32'h1111_0001;
    frame_rx  = {MSGID, 32'hB2B0_0001};
    bit_count = 16'd64;
    exp_q.push_back(32'hB2B0_0001);
    pulses_exp++;
    repeat (5) @(negedge clk);
    chk("b2b_tx_1", tx_frame, {MSGID, 32'h1111_0001});
    SPI_SSEL = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    SPI_SSEL  = 1'b0;
    status_in = 32'h2222_0002;
    repeat (3) @(negedge clk);
    frame_rx = {MSGID, 32'hB2B0_0002};
    exp_q.push_back(32'hB2B0_0002);
    pulses_exp++;
    repeat (2) @(negedge clk);
    chk("b2b_tx_2", tx_frame, {MSGID, 32'h2222_0002});
    SPI_SSEL = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("b2b_cmd_out", {32'h0, cmd_out}, 64'hB2B0_0002);

    // Reset asserted mid-frame and released with SSEL still low.
    @(negedge clk);
    SPI_SSEL  = 1'b0;
    status_in = 32'h5A5A_5A5A;
    frame_rx  = {MSGID, 32'hBAD0_BAD0};
    bit_count = 16'd64;
    rst_n     = 1'b0;
    @(negedge clk);
    check_reset_state();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    SPI_SSEL = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("held_low_no_snapshot", tx_frame, {MSGID, 32'h0});
    chk("held_low_no_commit", {32'h0, cmd_out}, 64'h0);
    chk("held_low_not_counted", {48'h0, short_cnt, bad_id_cnt}, 64'h0);

    // Next full frame after that commits normally.
    run_frame({MSGID, 32'h0F0F_1234}, 16'd64, 32'h3C3C_C3C3, 1'b1);
    chk("post_reset_commit", {32'h0, cmd_out}, 64'h0F0F_1234);

    repeat (4) @(negedge clk);
    chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("pulse_count", 64'(pulses_seen), 64'(pulses_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
